// File: rtl/rob_param_multicdb.sv
// Parametrised reorder buffer: in-order allocate, multi-CDB out-of-order capture, in-order commit.
// Optional macro ROB_CDB_BYPASS_EN adds a same-cycle CDB forward onto lookup and head outputs.
module rob_param_multicdb #(
    parameter int DEPTH   = 8,
    parameter int NUM_CDB = 2,
    localparam int TAG_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     alloc_en,
    input  logic [3:0]               alloc_opcode,
    input  logic [2:0]               alloc_dest,
    input  logic [15:0]              alloc_value,
    input  logic                     alloc_valid,
    input  logic                     alloc_predict,
    output logic [TAG_W-1:0]         alloc_tag,
    input  logic [NUM_CDB-1:0]       cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
    input  logic [NUM_CDB*16-1:0]    cdb_value,
    input  logic [TAG_W-1:0]         src1_tag,
    input  logic [TAG_W-1:0]         src2_tag,
    output logic [15:0]              src1_value,
    output logic [15:0]              src2_value,
    output logic                     src1_ready,
    output logic                     src2_ready,
    input  logic                     commit_en,
    output logic                     head_busy,
    output logic                     head_ready,
    output logic [3:0]               head_opcode,
    output logic [2:0]               head_dest,
    output logic [15:0]              head_value,
    output logic                     head_predict,
    output logic                     full,
    output logic                     empty,
    output logic [CNT_W-1:0]         count
);

    // Storage is rounded up to a power of two so every tag value indexes a
    // defined slot; slots at or beyond DEPTH are never allocated and stay idle.
    localparam int ENTRIES = 1 << TAG_W;

    logic        busy_q    [ENTRIES];
    logic        ready_q   [ENTRIES];
    logic [3:0]  opcode_q  [ENTRIES];
    logic [2:0]  dest_q    [ENTRIES];
    logic [15:0] value_q   [ENTRIES];
    logic        predict_q [ENTRIES];

    logic [TAG_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] count_q;
    logic             do_alloc, do_commit;

    function automatic logic [TAG_W-1:0] ptr_next(input logic [TAG_W-1:0] p);
        return (p == TAG_W'(DEPTH - 1)) ? '0 : p + TAG_W'(1);
    endfunction

    assign count     = count_q;
    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign alloc_tag = tail_q;
    assign do_alloc  = alloc_en && !full;
    assign do_commit = commit_en && head_busy && head_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the entry fields are reset too, not only busy/ready, so the
            // unqualified lookup values read as zero straight out of reset.
            for (int i = 0; i < ENTRIES; i++) begin
                busy_q[i]    <= 1'b0;
                ready_q[i]   <= 1'b0;
                opcode_q[i]  <= '0;
                dest_q[i]    <= '0;
                value_q[i]   <= '0;
                predict_q[i] <= 1'b0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                busy_q[i]  <= 1'b0;
                ready_q[i] <= 1'b0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            // NOTE: non-blocking writes to one entry resolve to the last one
            // executed, so ports are walked high to low to let port 0 win, and
            // commit/alloc follow the CDB loop so they override a capture.
            for (int p = NUM_CDB - 1; p >= 0; p--) begin
                if (cdb_valid[p] && busy_q[cdb_tag[p*TAG_W +: TAG_W]]
                    && !ready_q[cdb_tag[p*TAG_W +: TAG_W]]) begin
                    ready_q[cdb_tag[p*TAG_W +: TAG_W]] <= 1'b1;
                    value_q[cdb_tag[p*TAG_W +: TAG_W]] <= cdb_value[p*16 +: 16];
                end
            end
            if (do_commit) begin
                busy_q[head_q]  <= 1'b0;
                ready_q[head_q] <= 1'b0;
                head_q          <= ptr_next(head_q);
            end
            if (do_alloc) begin
                busy_q[tail_q]    <= 1'b1;
                ready_q[tail_q]   <= alloc_valid;
                opcode_q[tail_q]  <= alloc_opcode;
                dest_q[tail_q]    <= alloc_dest;
                value_q[tail_q]   <= alloc_value;
                predict_q[tail_q] <= alloc_predict;
                tail_q            <= ptr_next(tail_q);
            end
            case ({do_alloc, do_commit})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef ROB_CDB_BYPASS_EN
    // Returns {hit, value} of the lowest-numbered CDB port broadcasting tag t.
    function automatic logic [16:0] cdb_snoop(input logic [TAG_W-1:0] t,
                                              input logic [NUM_CDB-1:0] v,
                                              input logic [NUM_CDB*TAG_W-1:0] tags,
                                              input logic [NUM_CDB*16-1:0] vals);
        logic [16:0] r;
        r = '0;
        for (int p = NUM_CDB - 1; p >= 0; p--)
            if (v[p] && tags[p*TAG_W +: TAG_W] == t) r = {1'b1, vals[p*16 +: 16]};
        return r;
    endfunction

    logic [16:0] src1_hit, src2_hit, head_hit;
    assign src1_hit = cdb_snoop(src1_tag, cdb_valid, cdb_tag, cdb_value);
    assign src2_hit = cdb_snoop(src2_tag, cdb_valid, cdb_tag, cdb_value);
    assign head_hit = cdb_snoop(head_q, cdb_valid, cdb_tag, cdb_value);
`endif

    always_comb begin
        // NOTE: every output gets a registered-state default first; the
        // optional bypass only overrides, so no path can infer a latch.
        src1_ready = busy_q[src1_tag] && ready_q[src1_tag];
        src1_value = value_q[src1_tag];
        src2_ready = busy_q[src2_tag] && ready_q[src2_tag];
        src2_value = value_q[src2_tag];
        head_busy  = busy_q[head_q];
        head_ready = busy_q[head_q] && ready_q[head_q];
        head_value = busy_q[head_q] ? value_q[head_q] : '0;
`ifdef ROB_CDB_BYPASS_EN
        if (busy_q[src1_tag] && !ready_q[src1_tag] && src1_hit[16]) begin
            src1_ready = 1'b1;
            src1_value = src1_hit[15:0];
        end
        if (busy_q[src2_tag] && !ready_q[src2_tag] && src2_hit[16]) begin
            src2_ready = 1'b1;
            src2_value = src2_hit[15:0];
        end
        if (busy_q[head_q] && !ready_q[head_q] && head_hit[16]) begin
            head_ready = 1'b1;
            head_value = head_hit[15:0];
        end
`endif
    end

    assign head_opcode  = head_busy ? opcode_q[head_q]  : '0;
    assign head_dest    = head_busy ? dest_q[head_q]    : '0;
    assign head_predict = head_busy ? predict_q[head_q] : 1'b0;

endmodule

// File: tb/tb_rob_param_multicdb.sv
// Self-checking bench for rob_param_multicdb: directed scenarios plus random traffic
// compared against a queue-based model of the in-flight instruction window.
module tb_rob_param_multicdb;

    localparam int DEPTH   = 8;
    localparam int NUM_CDB = 2;
    localparam int TAG_W   = 3;
    localparam int CNT_W   = 4;
`ifdef ROB_CDB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     flush;
    logic                     alloc_en;
    logic [3:0]               alloc_opcode;
    logic [2:0]               alloc_dest;
    logic [15:0]              alloc_value;
    logic                     alloc_valid;
    logic                     alloc_predict;
    logic [TAG_W-1:0]         alloc_tag;
    logic [NUM_CDB-1:0]       cdb_valid;
    logic [NUM_CDB*TAG_W-1:0] cdb_tag;
    logic [NUM_CDB*16-1:0]    cdb_value;
    logic [TAG_W-1:0]         src1_tag, src2_tag;
    logic [15:0]              src1_value, src2_value;
    logic                     src1_ready, src2_ready;
    logic                     commit_en;
    logic                     head_busy, head_ready;
    logic [3:0]               head_opcode;
    logic [2:0]               head_dest;
    logic [15:0]              head_value;
    logic                     head_predict;
    logic                     full, empty;
    logic [CNT_W-1:0]         count;

    rob_param_multicdb #(.DEPTH(DEPTH), .NUM_CDB(NUM_CDB)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .alloc_en(alloc_en), .alloc_opcode(alloc_opcode), .alloc_dest(alloc_dest),
        .alloc_value(alloc_value), .alloc_valid(alloc_valid), .alloc_predict(alloc_predict),
        .alloc_tag(alloc_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .src1_tag(src1_tag), .src2_tag(src2_tag),
        .src1_value(src1_value), .src2_value(src2_value),
        .src1_ready(src1_ready), .src2_ready(src2_ready),
        .commit_en(commit_en),
        .head_busy(head_busy), .head_ready(head_ready), .head_opcode(head_opcode),
        .head_dest(head_dest), .head_value(head_value), .head_predict(head_predict),
        .full(full), .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: the window of in-flight instructions, oldest first.
    typedef struct {
        int          tag;
        logic [3:0]  opc;
        logic [2:0]  dest;
        logic [15:0] val;
        bit          rdy;
        logic        pred;
    } ent_t;

    ent_t rob_q[$];
    int   head_idx = 0;

    function automatic int find_tag(input int t);
        foreach (rob_q[k]) if (rob_q[k].tag == t) return k;
        return -1;
    endfunction

    function automatic bit cdb_first(input int t, output logic [15:0] v);
        v = '0;
        for (int p = 0; p < NUM_CDB; p++)
            if (cdb_valid[p] && int'(cdb_tag[p*TAG_W +: TAG_W]) == t) begin
                v = cdb_value[p*16 +: 16];
                return 1'b1;
            end
        return 1'b0;
    endfunction

    function automatic void exp_lookup(input int t, output bit rdy, output logic [15:0] val);
        int          k;
        logic [15:0] v;
        k   = find_tag(t);
        rdy = 1'b0;
        val = '0;
        if (k >= 0) begin
            if (rob_q[k].rdy) begin
                rdy = 1'b1;
                val = rob_q[k].val;
            end else if (BYP && cdb_first(t, v)) begin
                rdy = 1'b1;
                val = v;
            end
        end
    endfunction

    task automatic check_all();
        int          n;
        bit          r;
        logic [15:0] v;
        n = rob_q.size();
        check("count", 32'(count), 32'(n));
        check("empty", 32'(empty), 32'(n == 0));
        check("full", 32'(full), 32'(n == DEPTH));
        check("alloc_tag", 32'(alloc_tag), 32'((head_idx + n) % DEPTH));
        check("head_busy", 32'(head_busy), 32'(n > 0));
        if (n > 0) begin
            exp_lookup(rob_q[0].tag, r, v);
            check("head_ready", 32'(head_ready), 32'(r));
            if (r) check("head_value", 32'(head_value), 32'(v));
            check("head_opcode", 32'(head_opcode), 32'(rob_q[0].opc));
            check("head_dest", 32'(head_dest), 32'(rob_q[0].dest));
            check("head_predict", 32'(head_predict), 32'(rob_q[0].pred));
        end else begin
            check("head_ready_empty", 32'(head_ready), 32'(0));
            check("head_value_empty", 32'(head_value), 32'(0));
            check("head_fields_empty", {24'(head_opcode), 4'(head_dest), 4'(head_predict)}, 32'(0));
        end
        exp_lookup(int'(src1_tag), r, v);
        check("src1_ready", 32'(src1_ready), 32'(r));
        if (r) check("src1_value", 32'(src1_value), 32'(v));
        exp_lookup(int'(src2_tag), r, v);
        check("src2_ready", 32'(src2_ready), 32'(r));
        if (r) check("src2_value", 32'(src2_value), 32'(v));
    endtask

    function automatic void model_edge();
        int          n, tail, k;
        bit          hr, commit_ok, alloc_ok;
        logic [15:0] hv;
        ent_t        e;
        if (flush) begin
            rob_q.delete();
            head_idx = 0;
            return;
        end
        n    = rob_q.size();
        tail = (head_idx + n) % DEPTH;
        hr   = 1'b0;
        if (n > 0) exp_lookup(rob_q[0].tag, hr, hv);
        commit_ok = commit_en && n > 0 && hr;
        alloc_ok  = alloc_en && n < DEPTH;
        for (int p = 0; p < NUM_CDB; p++) begin
            if (cdb_valid[p]) begin
                k = find_tag(int'(cdb_tag[p*TAG_W +: TAG_W]));
                if (k >= 0 && !rob_q[k].rdy) begin
                    rob_q[k].rdy = 1'b1;
                    rob_q[k].val = cdb_value[p*16 +: 16];
                end
            end
        end
        if (commit_ok) begin
            void'(rob_q.pop_front());
            head_idx = (head_idx + 1) % DEPTH;
        end
        if (alloc_ok) begin
            e.tag  = tail;
            e.opc  = alloc_opcode;
            e.dest = alloc_dest;
            e.val  = alloc_value;
            e.rdy  = alloc_valid;
            e.pred = alloc_predict;
            rob_q.push_back(e);
        end
    endfunction

    task automatic idle();
        flush = 1'b0; alloc_en = 1'b0; commit_en = 1'b0; cdb_valid = '0;
        alloc_opcode = '0; alloc_dest = '0; alloc_value = '0;
        alloc_valid = 1'b0; alloc_predict = 1'b0;
        cdb_tag = '0; cdb_value = '0;
    endtask

    // Checks outputs against the model, then clocks both; returns just after negedge.
    task automatic step();
        #1;
        check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic alloc(input logic [3:0] opc, input logic [15:0] val, input logic valid);
        alloc_en = 1'b1; alloc_opcode = opc; alloc_dest = opc[2:0];
        alloc_value = val; alloc_valid = valid; alloc_predict = opc[0];
        step();
        idle();
    endtask

    task automatic cdb_drive(input int port, input int tag, input logic [15:0] val);
        cdb_valid[port] = 1'b1;
        cdb_tag[port*TAG_W +: TAG_W] = TAG_W'(tag);
        cdb_value[port*16 +: 16] = val;
    endtask

    initial begin
        rst_n = 1'b0;
        src1_tag = '0;
        src2_tag = '0;
        idle();
        @(negedge clk);
        #1;
        check_all();
        check("rst_empty", 32'(empty), 32'(1));
        @(negedge clk);
        rst_n = 1'b1;

        // Fill to full; the wrap of alloc_tag and the ignored ninth alloc.
        for (int i = 0; i < DEPTH; i++) alloc(4'(i), 16'h1000 + 16'(i), i == 0);
        #1;
        check("fill_full", 32'(full), 32'(1));
        check("fill_count", 32'(count), 32'(8));
        check("fill_tag_wrap", 32'(alloc_tag), 32'(0));
        alloc(4'hF, 16'hDEAD, 1'b1);
        #1;
        check("overfill_count", 32'(count), 32'(8));

        // Full with commit+alloc: commit happens, alloc is dropped.
        alloc_en = 1'b1; commit_en = 1'b1; alloc_valid = 1'b1;
        step();
        idle();
        #1;
        check("full_commit_count", 32'(count), 32'(7));
        check("full_commit_tag", 32'(alloc_tag), 32'(0));

        flush = 1'b1; alloc_en = 1'b1; commit_en = 1'b1;
        step();
        idle();
        #1;
        check("flush_count", 32'(count), 32'(0));
        check("flush_empty", 32'(empty), 32'(1));

        // Out-of-order completion.
        for (int i = 0; i < 3; i++) alloc(4'(i + 1), 16'h0, 1'b0);
        cdb_drive(1, 2, 16'hBEEF);
        step();
        idle();
        cdb_drive(0, 0, 16'h1234);
        step();
        idle();
        #1;
        check("ooo_head_ready", 32'(head_ready), 32'(1));
        check("ooo_head_value", 32'(head_value), 32'h1234);
        commit_en = 1'b1;
        step();
        idle();
        src1_tag = 3'd2;
        #1;
        check("ooo_head_block", 32'(head_ready), 32'(0));
        check("ooo_tag2_ready", 32'(src1_ready), 32'(1));
        check("ooo_tag2_value", 32'(src1_value), 32'hBEEF);
        commit_en = 1'b1;
        step();
        idle();
        #1;
        check("ooo_blocked_count", 32'(count), 32'(2));

        // Two ports, same tag: port 0 wins.
        alloc(4'h5, 16'h0, 1'b0);
        cdb_drive(0, 3, 16'h0001);
        cdb_drive(1, 3, 16'h0002);
        step();
        idle();
        src2_tag = 3'd3;
        #1;
        check("dual_ready", 32'(src2_ready), 32'(1));
        check("dual_value", 32'(src2_value), 32'h0001);

        // Same-cycle CDB forward onto a lookup.
        alloc(4'h6, 16'h0, 1'b0);
        src1_tag = 3'd4;
        cdb_drive(0, 4, 16'h00AA);
        #1;
        check("byp_ready", 32'(src1_ready), 32'(BYP));
        step();
        idle();
        #1;
        check("byp_next_ready", 32'(src1_ready), 32'(1));
        check("byp_next_value", 32'(src1_value), 32'h00AA);

        // Asynchronous reset mid-run with five entries live.
        alloc(4'h7, 16'h0, 1'b0);
        #1;
        check("pre_rst_count", 32'(count), 32'(5));
        #1;
        rst_n = 1'b0;
        rob_q.delete();
        head_idx = 0;
        #1;
        check("rst_empty", 32'(empty), 32'(1));
        check("rst_count", 32'(count), 32'(0));
        check("rst_alloc_tag", 32'(alloc_tag), 32'(0));
        check("rst_head_busy", 32'(head_busy), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            flush         = ($urandom_range(0, 39) == 0);
            alloc_en      = ($urandom_range(0, 9) < 6);
            alloc_opcode  = 4'($urandom);
            alloc_dest    = 3'($urandom);
            alloc_value   = 16'($urandom);
            alloc_valid   = ($urandom_range(0, 3) == 0);
            alloc_predict = 1'($urandom);
            commit_en     = 1'($urandom);
            for (int p = 0; p < NUM_CDB; p++) begin
                cdb_valid[p] = ($urandom_range(0, 2) == 0);
                if (rob_q.size() > 0 && $urandom_range(0, 3) != 0)
                    cdb_tag[p*TAG_W +: TAG_W] = TAG_W'(rob_q[$urandom_range(0, rob_q.size() - 1)].tag);
                else
                    cdb_tag[p*TAG_W +: TAG_W] = TAG_W'($urandom_range(0, DEPTH - 1));
                cdb_value[p*16 +: 16] = 16'($urandom);
            end
            src1_tag = TAG_W'($urandom_range(0, DEPTH - 1));
            src2_tag = TAG_W'($urandom_range(0, DEPTH - 1));
            step();
        end
        idle();
        #1;
        check_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
